mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter with a small TX FIFO.
// Register window: TXDATA at BASE_ADDR+0 (write pushes a byte), STATUS at
// BASE_ADDR+4 (read {overflow, full, empty, busy}; write bit 3 clears overflow).
// Frames are 8N1, LSB first, each bit lasting CLKS_PER_BIT clocks.
module mmio_uart_tx #(
    parameter int unsigned    W            = 32,
    parameter int unsigned    CLKS_PER_BIT = 16,
    parameter logic [W-1:0]   BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned    DEPTH        = 4
) (
    input  logic         clk_t,
    input  logic         rst_t,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         tx,
    output logic         busy
);

    localparam int unsigned  AW          = $clog2(DEPTH);
    localparam int unsigned  BW          = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] TXDATA_ADDR = BASE_ADDR;
    localparam logic [W-1:0] STATUS_ADDR = BASE_ADDR + W'(32'd4);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]  FULL_COUNT  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Transmitter state
    state_t        state_r;
    state_t        state_s;
    logic [BW-1:0] baud_r;
    logic [2:0]    bit_r;
    logic [7:0]    shift_r;
    logic          tx_r;

    // FIFO state
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic          ovf_r;

    // Decoded strobes and FSM controls
    logic          push_s;
    logic          accept_s;
    logic          drop_s;
    logic          clr_ovf_s;
    logic          pop_s;
    logic          enter_s;
    logic          shift_s;
    logic          tx_s;
    logic          baud_done_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          busy_s;
    logic          unused_wdata_s;

    assign fifo_empty_s = (count_r == {(AW+1){1'b0}});
    assign fifo_full_s  = (count_r == FULL_COUNT);
    assign busy_s       = (state_r != IDLE) | ~fifo_empty_s;
    assign baud_done_s  = (baud_r == {BW{1'b0}});

    // A push while full is only accepted when the transmitter frees a slot on the same edge.
    assign push_s    = wr_en & (addr == TXDATA_ADDR);
    assign accept_s  = push_s & (~fifo_full_s | pop_s);
    assign drop_s    = push_s & fifo_full_s & ~pop_s;
    assign clr_ovf_s = wr_en & (addr == STATUS_ADDR) & wdata[3];

    assign unused_wdata_s = ^wdata[W-1:8];

    assign tx   = tx_r;
    assign busy = busy_s;

    // FSM state register
    always_ff @(posedge clk_t) begin
        if (rst_t) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state, pop/shift controls and next line level
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        enter_s = 1'b0;
        shift_s = 1'b0;
        tx_s    = 1'b1;
        case (state_r)
            IDLE: begin
                tx_s = 1'b1;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    enter_s = 1'b1;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                tx_s = 1'b0;
                if (baud_done_s) begin
                    enter_s = 1'b1;
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                tx_s = shift_r[0];
                if (baud_done_s) begin
                    enter_s = 1'b1;
                    shift_s = 1'b1;
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                tx_s = 1'b1;
                if (baud_done_s) begin
                    enter_s = 1'b1;
                    // Chain straight into the next frame so queued bytes leave without a gap.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_s = START;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                tx_s    = 1'b1;
                state_s = IDLE;
            end
        endcase
    end

    // Baud timing, bit index, shift register and registered serial line
    always_ff @(posedge clk_t) begin
        if (rst_t) begin
            baud_r  <= {BW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            tx_r <= tx_s;
            if (enter_s) begin
                baud_r <= BAUD_RELOAD;
            end else if (!baud_done_s) begin
                baud_r <= baud_r - BW'(1'b1);
            end
            if (pop_s) begin
                shift_r <= mem_r[rptr_r];
                bit_r   <= 3'd0;
            end else if (shift_s) begin
                shift_r <= {1'b0, shift_r[7:1]};
                bit_r   <= bit_r + 3'd1;
            end
        end
    end

    // FIFO storage; stale entries are harmless because the pointers are reset
    always_ff @(posedge clk_t) begin
        if (!rst_t && accept_s) begin
            mem_r[wptr_r] <= wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk_t) begin
        if (rst_t) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                wptr_r <= wptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1'b1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
            // A new overflow wins over a clear on the same edge.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Load data: only STATUS returns content, everything else reads as zero
    always_comb begin
        rdata = {W{1'b0}};
        if (rd_en && (addr == STATUS_ADDR)) begin
            rdata = {{(W-4){1'b0}}, ovf_r, fifo_full_s, fifo_empty_s, busy_s};
        end else begin
            rdata = {W{1'b0}};
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode table, directed frame sequences and a random
// run, all compared against a frame-position reference model.
module tb_mmio_uart_tx;

    localparam int          C    = 4;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk_t = 1'b0;
    logic        rst_t = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    always #5 clk_t = ~clk_t;

    mmio_uart_tx #(
        .W(32), .CLKS_PER_BIT(C), .BASE_ADDR(BASE), .DEPTH(D)
    ) dut (
        .clk_t(clk_t), .rst_t(rst_t), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int falls = 0;
    logic prev_tx = 1'b1;

    // Reference model: queued bytes plus position (in clocks) within the current frame.
    logic [7:0] mq[$];
    int         pos  = -1;
    logic [7:0] cur  = 8'h00;
    logic       movf = 1'b0;
    logic       mtx  = 1'b1;

    function automatic logic m_busy();
        return (pos >= 0) || (mq.size() != 0);
    endfunction

    function automatic logic line_level(input int p, input logic [7:0] b);
        if (p < 0)     return 1'b1;
        if (p < C)     return 1'b0;
        if (p < 9 * C) return b[p / C - 1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_rdata(input logic r, input logic [31:0] a);
        if (r && a == BASE + 32'd4)
            return {28'd0, movf, (mq.size() == D), (mq.size() == 0), m_busy()};
        return 32'd0;
    endfunction

    task automatic m_edge(input logic w, input logic rs, input logic [31:0] a, input logic [31:0] wd);
        logic pop;
        logic drop;
        int sz;
        logic [7:0] nb;
        if (rs) begin
            mq.delete();
            pos = -1; movf = 1'b0; mtx = 1'b1; cur = 8'h00;
        end else begin
            mtx  = line_level(pos, cur);
            sz   = mq.size();
            pop  = ((pos < 0) || (pos == 10 * C - 1)) && (sz > 0);
            drop = 1'b0;
            nb   = cur;
            if (pop) nb = mq.pop_front();
            if (w && a == BASE) begin
                if (sz < D || pop) mq.push_back(wd[7:0]);
                else drop = 1'b1;
            end
            if (drop) movf = 1'b1;
            else if (w && a == BASE + 32'd4 && wd[3]) movf = 1'b0;
            if (pop) begin
                pos = 0; cur = nb;
            end else if (pos >= 0) begin
                pos = (pos == 10 * C - 1) ? -1 : pos + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check load data, clock the model, check outputs at next negedge.
    task automatic step(input logic w, input logic r, input logic rs, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] obs);
        wr_en = w; rd_en = r; rst_t = rs; addr = a; wdata = wd;
        #1;
        obs = rdata;
        check("rdata", rdata, m_rdata(r, a));
        @(posedge clk_t);
        m_edge(w, rs, a, wd);
        @(negedge clk_t);
        check("tx", 32'(tx), 32'(mtx));
        check("busy", 32'(busy), 32'(m_busy()));
        if (prev_tx === 1'b1 && tx === 1'b0) falls++;
        prev_tx = tx;
    endtask

    task automatic idle(input int n);
        logic [31:0] o;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, o);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] o;
        step(1'b1, 1'b0, 1'b0, a, d, o);
    endtask

    task automatic rdchk(input string name, input logic [31:0] exp);
        logic [31:0] o;
        step(1'b0, 1'b1, 1'b0, BASE + 32'd4, 32'd0, o);
        check(name, o, exp);
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t       tbl[9];
    logic       txa[100];
    logic       bsa[100];
    logic       pat[10];
    logic [31:0] o;
    int         dens;
    int         sel;
    logic       rw, rr, rrs;
    logic [31:0] ra, rwd;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'd4,  32'd0,  32'h2};   // reset STATUS: empty only
        tbl[1] = '{1'b0, 1'b1, 32'd0,  32'd0,  32'h0};   // TXDATA reads zero
        tbl[2] = '{1'b1, 1'b0, 32'd8,  32'h55, 32'h0};   // store outside window
        tbl[3] = '{1'b0, 1'b1, 32'd12, 32'd0,  32'h0};   // load outside window
        tbl[4] = '{1'b0, 1'b1, 32'd4,  32'd0,  32'h2};   // no push happened
        tbl[5] = '{1'b1, 1'b0, 32'd4,  32'h8,  32'h0};   // clear with no overflow
        tbl[6] = '{1'b0, 1'b1, 32'd4,  32'd0,  32'h2};
        tbl[7] = '{1'b0, 1'b1, 32'd1,  32'd0,  32'h0};   // misaligned
        tbl[8] = '{1'b0, 1'b0, 32'd4,  32'd0,  32'h0};   // rd_en low
        pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        @(negedge clk_t);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, o);
        check("reset_tx", 32'(tx), 32'd1);

        // Decode table
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].w, tbl[i].r, 1'b0, BASE + tbl[i].off, tbl[i].wd, o);
            check($sformatf("vec%0d", i), o, tbl[i].exp);
        end

        // Single byte 0xA5: edge 0 pushes, start bit visible after edge 2
        st(BASE, 32'h0000_00A5);
        for (int n = 1; n < 46; n++) begin
            idle(1);
            txa[n] = tx; bsa[n] = busy;
        end
        check("latency_pre", 32'(txa[1]), 32'd1);
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < C; j++)
                check($sformatf("a5_bit%0d", i), 32'(txa[2 + C * i + j]), 32'(pat[i]));
        check("a5_busy_stop", 32'(bsa[40]), 32'd1);
        check("a5_busy_fall", 32'(bsa[41]), 32'd0);
        check("a5_idle_tx", 32'(txa[45]), 32'd1);

        // Back-to-back frames with no idle gap
        st(BASE, 32'h01);
        st(BASE, 32'h02);
        for (int n = 2; n < 90; n++) begin
            idle(1);
            txa[n] = tx; bsa[n] = busy;
        end
        check("b2b_stop1", 32'(txa[41]), 32'd1);
        check("b2b_start2", 32'(txa[42]), 32'd0);
        for (int n = 2; n <= 80; n++) check("b2b_busy", 32'(bsa[n]), 32'd1);
        check("b2b_busy_fall", 32'(bsa[81]), 32'd0);
        rdchk("b2b_status", 32'h2);

        // Overflow: six stores, sixth dropped, then clear
        for (int i = 0; i < 6; i++) st(BASE, 32'h10 + 32'(i));
        rdchk("ovf_status", 32'hD);
        st(BASE + 32'd4, 32'h08);
        rdchk("ovf_cleared", 32'h5);
        idle(220);
        rdchk("ovf_drained", 32'h2);

        // Full FIFO with a store on the STOP-to-START pop edge
        falls = 0; prev_tx = tx;
        for (int i = 0; i < 5; i++) st(BASE, 32'hFF);
        idle(36);
        st(BASE, 32'hFF);
        rdchk("full_pop_status", 32'h5);
        idle(280);
        check("full_pop_frames", 32'(falls), 32'd6);
        rdchk("full_pop_end", 32'h2);

        // Reset during DATA bit 3
        st(BASE, 32'hA5);
        st(BASE, 32'h33);
        st(BASE, 32'hC3);
        idle(15);
        check("pre_rst_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, o);
        check("rst_tx", 32'(tx), 32'd1);
        rdchk("rst_status", 32'h2);
        falls = 0; prev_tx = tx;
        idle(100);
        check("rst_no_frames", 32'(falls), 32'd0);

        // Random traffic against the model
        dens = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) dens = $urandom_range(1, 12);
            rw  = ($urandom_range(0, 15) < dens);
            rr  = 1'($urandom_range(0, 1));
            rrs = ($urandom_range(0, 599) == 0);
            sel = $urandom_range(0, 7);
            if (sel <= 4)      ra = BASE;
            else if (sel == 5) ra = BASE + 32'd4;
            else if (sel == 6) ra = BASE + 32'd8;
            else               ra = $urandom;
            rwd = $urandom;
            step(rw, rr, rrs, ra, rwd, o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
